// File: rtl/dcfifo_wr_ctrl.sv
// Dual-clock FIFO write-side control: pointers, Gray export, and
// full / almost-full / level / overflow flags in the write domain.
module dcfifo_wr_ctrl #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_err
);

  localparam int A     = ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [A:0] AF_TH = PW'(DEPTH - ALMOST_FULL_MARGIN);

  logic [A:0] wr_bin;
  logic [A:0] wr_bin_next;
  logic [A:0] gray_next;
  logic [A:0] rd_bin;
  logic [A:0] level_next;
  logic       full_next;

  assign mem_we      = wr_en & ~full;
  assign wr_addr     = wr_bin[A-1:0];
  assign wr_bin_next = wr_bin + PW'(mem_we);
  assign gray_next   = wr_bin_next ^ (wr_bin_next >> 1);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= A; i++) begin
      rd_bin[i] = ^(rd_ptr_gray_sync >> i);
    end
  end

  assign level_next = wr_bin_next - rd_bin;
  assign full_next  = (gray_next ==
    {~rd_ptr_gray_sync[A:A-1], rd_ptr_gray_sync[A-2:0]});

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      wr_err      <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= gray_next;
      full        <= full_next;
      almost_full <= (level_next >= AF_TH);
      wr_level    <= level_next;
      wr_err      <= wr_en & full;
    end
  end

endmodule

// File: doc/dcfifo_wr_ctrl.md
# dcfifo_wr_ctrl

Write-side control for the dual-clock FIFO. It runs entirely in the write clock domain. It accepts write requests and produces the RAM write enable and address. It keeps the binary and Gray write pointers and drives the registered Gray write pointer into the read-domain flip-flop synchronizer. It consumes the already-synchronized Gray read pointer to generate full, almost-full, fill level and overflow indication.

## Interface
- One clock; reset is synchronous and active-low.
- Parameters:
  - ADDR_WIDTH, default 4: RAM address width. Depth = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits. Legal range ≥ 2.
  - ALMOST_FULL_MARGIN, default 2: almost_full asserts when the level is ≥ depth − margin. Legal range 1..depth−1.
- Ports:
  - clk, input, 1: write-domain clock.
  - rst, input, 1: synchronous reset, active-low (0 = reset).
  - wr_en, input, 1: write request from the producer.
  - rd_ptr_gray_sync, input, ADDR_WIDTH+1: Gray read pointer, already synchronized into clk.
  - mem_we, output, 1: RAM write enable. Combinational: wr_en & ~full.
  - wr_addr, output, ADDR_WIDTH: RAM write address, equal to wr_bin[ADDR_WIDTH-1:0].
  - wr_ptr_gray, output, ADDR_WIDTH+1: registered Gray write pointer, sent to the read-domain synchronizer.
  - full, output, 1: registered full flag.
  - almost_full, output, 1: registered almost-full flag.
  - wr_level, output, ADDR_WIDTH+1: registered fill level as seen from the write side, 0..depth.
  - wr_err, output, 1: registered one-cycle pulse for a write attempted while full.

## Operation
- State registers:
  - wr_bin, ADDR_WIDTH+1 bits.
  - wr_ptr_gray.
  - full, almost_full, wr_level, wr_err.
- Reset (rst=0 at a clk edge):
  - All registers are cleared to 0, so full=0, almost_full=0, wr_level=0, wr_err=0, wr_ptr_gray=0 and wr_addr=0.
  - mem_we follows wr_en & ~full, so it may be 1 during reset if wr_en=1.
  - The producer must hold wr_en low during reset.
- Accepted write: mem_we=1.
  - wr_bin_next = wr_bin + 1, modulo 2**(ADDR_WIDTH+1). The pointer wraps from all-ones to 0 naturally.
  - Otherwise wr_bin_next = wr_bin.
- Gray encoding: wr_ptr_gray <= wr_bin_next ^ (wr_bin_next >> 1).
  - Only one bit of wr_ptr_gray changes per accepted write. This property is mandatory for the synchronizer.
- Full detection: full <= (gray(wr_bin_next) == {~rd_ptr_gray_sync[A:A-1], rd_ptr_gray_sync[A-2:0]}), with A = ADDR_WIDTH.
- Level:
  - rd_bin = Gray-to-binary of rd_ptr_gray_sync, computed with an XOR prefix from the MSB down.
  - wr_level <= wr_bin_next − rd_bin, modulo 2**(A+1).
  - almost_full <= (wr_bin_next − rd_bin) ≥ 2**A − ALMOST_FULL_MARGIN.
- Overflow: wr_err <= wr_en & full.
  - A rejected write changes no state other than wr_err.
- Pessimism: flags are computed against a stale read pointer.
  - full and almost_full may stay high longer than necessary.
  - They never deassert early, and the FIFO can never be overrun.
- Gray inputs carry one-bit changes only. rd_ptr_gray_sync is assumed to be a valid Gray code at every edge; no checking is performed.

## Timing
- Accepted write at edge N:
  - RAM is written at edge N with wr_addr.
  - wr_ptr_gray, full, almost_full and wr_level update at edge N (visible in cycle N+1).
- The write that fills the FIFO raises full in the following cycle. A back-to-back wr_en in that cycle is rejected.
- A change of rd_ptr_gray_sync is reflected in full, almost_full and wr_level one cycle later.
  - Total read-to-write flag latency is this cycle plus the synchronizer's STAGES+1 cycles.
- Simultaneous write and read-pointer change in the same cycle: both enter the next-cycle computation. wr_level is unchanged if both advance by one.
- A write while full=1: mem_we=0 combinationally, and a wr_err pulse appears in the next cycle.
- Reset mid-operation: the next cycle shows all outputs at 0 regardless of any pending wr_en. The read side must be reset in the same window.

## Test plan
1. Reset: hold rst=0 for 2 cycles with wr_en=0.
   - Required: full=0, almost_full=0, wr_level=0, wr_ptr_gray=00000, wr_addr=0, wr_err=0.
2. Fill: 16 back-to-back writes with rd_ptr_gray_sync=00000 (ADDR_WIDTH=4).
   - wr_addr steps 0..15.
   - wr_ptr_gray steps 00001, 00011, 00010, 00110 … ending at 11000.
   - almost_full rises after the 14th write.
   - full rises after the 16th write; wr_level=16.
3. Overflow: 17th wr_en while full.
   - Required: mem_we=0, wr_err=1 for exactly one cycle, wr_ptr_gray stays 11000, wr_level stays 16.
4. Drain release: from full, drive rd_ptr_gray_sync=00001.
   - Required: next cycle full=0, wr_level=15, almost_full=1.
   - Then drive rd_ptr_gray_sync=00011: wr_level=14, almost_full=1.
   - Then drive 00010: wr_level=13, almost_full=0.
5. Wrap-around: stream 40 writes while rd_ptr_gray_sync tracks wr_ptr_gray with a 2-cycle delay.
   - wr_ptr_gray passes 10000 (binary 31) → 00000 (binary 0) with a single-bit change.
   - full never asserts.
   - wr_addr wraps 15 → 0.
6. Mid-operation reset: with wr_level=9 and wr_en=1, pulse rst=0 for one cycle.
   - Required: next cycle all outputs are 0, wr_ptr_gray=00000, and the following write goes to wr_addr=0.
